// File: rtl/pc_trap_sequencer_if.sv
// pc_trap_sequencer_if: decode-class inputs and PC/CSR strobe outputs of the trap sequencer
interface pc_trap_sequencer_if;
    logic        exec_stall;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        is_mret;
    logic        is_ecall;
    logic        illegal;
    logic        br_taken;
    logic        intr;
    logic        csr_mie_we;
    logic        csr_mie_wdata;
    logic [2:0]  pcSource;
    logic        pcWrite;
    logic        pc_reset;
    logic        irWrite;
    logic        mepcWrite;
    logic        mcauseWrite;
    logic [31:0] mcause;
    logic        mie;
    logic        mpie;
    logic [2:0]  state;

    modport master (
        output exec_stall, is_jal, is_jalr, is_branch, is_mret, is_ecall, illegal,
               br_taken, intr, csr_mie_we, csr_mie_wdata,
        input  pcSource, pcWrite, pc_reset, irWrite, mepcWrite, mcauseWrite,
               mcause, mie, mpie, state
    );

    modport slave (
        input  exec_stall, is_jal, is_jalr, is_branch, is_mret, is_ecall, illegal,
               br_taken, intr, csr_mie_we, csr_mie_wdata,
        output pcSource, pcWrite, pc_reset, irWrite, mepcWrite, mcauseWrite,
               mcause, mie, mpie, state
    );
endinterface

// File: rtl/pc_trap_sequencer.sv
// pc_trap_sequencer: multicycle fetch/decode/exec control with ecall, illegal and interrupt traps
module pc_trap_sequencer #(
    parameter logic [31:0] INTR_CAUSE   = 32'h8000_000B,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input logic clk,
    input logic reset_n,
    pc_trap_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        INIT   = 3'b000,
        FETCH  = 3'b001,
        DECODE = 3'b010,
        EXEC   = 3'b011,
        TRAP   = 3'b100
    } state_t;

    state_t      cur, nxt;
    logic [31:0] cause_q, cause_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic        run, trapping, mret_done, intr_take;

    always_comb begin
        run       = (cur == EXEC) && !bus.exec_stall;
        trapping  = run && (bus.is_ecall || (bus.illegal && ILLEGAL_TRAP));
        mret_done = run && !trapping && bus.is_mret;
        // interrupts are judged against mie as registered before this cycle
        intr_take = run && !trapping && bus.intr && mie_q;
    end

    always_comb begin
        nxt             = INIT;
        bus.pcSource    = 3'b000;
        bus.pcWrite     = 1'b0;
        bus.pc_reset    = 1'b0;
        bus.irWrite     = 1'b0;
        bus.mepcWrite   = 1'b0;
        bus.mcauseWrite = 1'b0;
        case (cur)
            INIT: begin
                bus.pc_reset = 1'b1;
                nxt          = FETCH;
            end
            FETCH: begin
                bus.irWrite = 1'b1;
                nxt         = DECODE;
            end
            DECODE: nxt = EXEC;
            EXEC: begin
                if (bus.exec_stall) nxt = EXEC;
                else if (trapping) nxt = TRAP;
                else begin
                    bus.pcWrite  = 1'b1;
                    bus.pcSource = bus.is_mret ? 3'b101 :
                                   bus.is_jalr ? 3'b001 :
                                   bus.is_jal ? 3'b011 :
                                   (bus.is_branch && bus.br_taken) ? 3'b010 : 3'b000;
                    nxt          = intr_take ? TRAP : FETCH;
                end
            end
            TRAP: begin
                bus.mepcWrite   = 1'b1;
                bus.mcauseWrite = 1'b1;
                bus.pcSource    = 3'b100;
                bus.pcWrite     = 1'b1;
                nxt             = FETCH;
            end
            default: nxt = INIT;
        endcase
    end

    always_comb begin
        mie_d   = (cur == TRAP) ? 1'b0 : mret_done ? mpie_q :
                  bus.csr_mie_we ? bus.csr_mie_wdata : mie_q;
        mpie_d  = (cur == TRAP) ? mie_q : mret_done ? 1'b1 : mpie_q;
        cause_d = !run ? cause_q :
                  bus.is_ecall ? 32'h0000_000B :
                  (bus.illegal && ILLEGAL_TRAP) ? 32'h0000_0002 :
                  intr_take ? INTR_CAUSE : cause_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur     <= INIT;
            mie_q   <= 1'b0;
            mpie_q  <= 1'b0;
            cause_q <= 32'h0;
        end else begin
            cur     <= nxt;
            mie_q   <= mie_d;
            mpie_q  <= mpie_d;
            cause_q <= cause_d;
        end
    end

    assign bus.mcause = cause_q;
    assign bus.mie    = mie_q;
    assign bus.mpie   = mpie_q;
    assign bus.state  = cur;
endmodule

// File: tb/tb_pc_trap_sequencer.sv
// tb_pc_trap_sequencer: directed scenario tasks with hand-computed expectations
module tb_pc_trap_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_trap_sequencer_if bus ();

    pc_trap_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.exec_stall = 0; bus.is_jal = 0; bus.is_jalr = 0; bus.is_branch = 0;
        bus.is_mret = 0; bus.is_ecall = 0; bus.illegal = 0; bus.br_taken = 0;
        bus.intr = 0; bus.csr_mie_we = 0; bus.csr_mie_wdata = 0;
    endtask

    // from FETCH, advance to the first EXEC cycle
    task automatic to_exec();
        step();
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        #3;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0h want 0", bus.state); end
        checks++; if (bus.pc_reset !== 1'b1) begin errors++; $display("FAIL reset_pc_reset got %0b want 1", bus.pc_reset); end
        checks++; if (bus.mie !== 1'b0 || bus.mpie !== 1'b0) begin errors++; $display("FAIL reset_mie got %0b/%0b want 0/0", bus.mie, bus.mpie); end
        checks++; if (bus.mcause !== 32'h0) begin errors++; $display("FAIL reset_mcause got %0h want 0", bus.mcause); end
        checks++; if ({bus.pcWrite, bus.irWrite, bus.mepcWrite, bus.mcauseWrite, bus.pcSource} !== 7'd0) begin errors++; $display("FAIL reset_strobes got %0h want 0", {bus.pcWrite, bus.irWrite, bus.mepcWrite, bus.mcauseWrite, bus.pcSource}); end
        step();
        step();
        reset_n = 1;
        #1;
    endtask

    task automatic test_alu();
        checks++; if (bus.state !== 3'd0 || bus.pc_reset !== 1'b1) begin errors++; $display("FAIL alu_init got %0h/%0b want 0/1", bus.state, bus.pc_reset); end
        step();
        checks++; if (bus.state !== 3'd1 || bus.irWrite !== 1'b1 || bus.pc_reset !== 1'b0) begin errors++; $display("FAIL alu_fetch got %0h/%0b want 1/1", bus.state, bus.irWrite); end
        step();
        checks++; if (bus.state !== 3'd2 || bus.pcWrite !== 1'b0 || bus.irWrite !== 1'b0) begin errors++; $display("FAIL alu_decode got %0h/%0b want 2/0", bus.state, bus.pcWrite); end
        step();
        checks++; if (bus.state !== 3'd3 || bus.pcWrite !== 1'b1 || bus.pcSource !== 3'd0) begin errors++; $display("FAIL alu_exec got %0h/%0b/%0h want 3/1/0", bus.state, bus.pcWrite, bus.pcSource); end
        step();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL alu_refetch got %0h want 1", bus.state); end
    endtask

    task automatic test_pc_select();
        to_exec();
        bus.is_branch = 1; bus.br_taken = 1; #1;
        checks++; if (bus.pcSource !== 3'd2 || bus.pcWrite !== 1'b1) begin errors++; $display("FAIL branch_taken got %0h/%0b want 2/1", bus.pcSource, bus.pcWrite); end
        step(); clear_inputs();
        to_exec();
        bus.is_branch = 1; bus.br_taken = 0; #1;
        checks++; if (bus.pcSource !== 3'd0 || bus.pcWrite !== 1'b1) begin errors++; $display("FAIL branch_not_taken got %0h/%0b want 0/1", bus.pcSource, bus.pcWrite); end
        step(); clear_inputs();
        to_exec();
        bus.is_jalr = 1; #1;
        checks++; if (bus.pcSource !== 3'd1) begin errors++; $display("FAIL jalr got %0h want 1", bus.pcSource); end
        step(); clear_inputs();
        to_exec();
        bus.is_jal = 1; #1;
        checks++; if (bus.pcSource !== 3'd3) begin errors++; $display("FAIL jal got %0h want 3", bus.pcSource); end
        step(); clear_inputs();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL jal_next got %0h want 1", bus.state); end
    endtask

    task automatic test_stall();
        to_exec();
        bus.exec_stall = 1; bus.is_jal = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.state !== 3'd3 || bus.pcWrite !== 1'b0 || bus.pcSource !== 3'd0) begin errors++; $display("FAIL stall_%0d got %0h/%0b/%0h want 3/0/0", i, bus.state, bus.pcWrite, bus.pcSource); end
            if (i < 2) step();
        end
        bus.exec_stall = 0; #1;
        checks++; if (bus.pcWrite !== 1'b1 || bus.pcSource !== 3'd3) begin errors++; $display("FAIL stall_release got %0b/%0h want 1/3", bus.pcWrite, bus.pcSource); end
        step(); clear_inputs();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL stall_next got %0h want 1", bus.state); end
    endtask

    task automatic test_ecall();
        bus.csr_mie_we = 1; bus.csr_mie_wdata = 1;
        step(); clear_inputs();
        checks++; if (bus.mie !== 1'b1) begin errors++; $display("FAIL csr_mie_set got %0b want 1", bus.mie); end
        step();
        bus.is_ecall = 1; #1;
        checks++; if (bus.pcWrite !== 1'b0 || bus.pcSource !== 3'd0) begin errors++; $display("FAIL ecall_exec got %0b/%0h want 0/0", bus.pcWrite, bus.pcSource); end
        step(); clear_inputs();
        checks++; if (bus.state !== 3'd4 || bus.mepcWrite !== 1'b1 || bus.mcauseWrite !== 1'b1) begin errors++; $display("FAIL ecall_trap got %0h/%0b/%0b want 4/1/1", bus.state, bus.mepcWrite, bus.mcauseWrite); end
        checks++; if (bus.mcause !== 32'h0000_000B) begin errors++; $display("FAIL ecall_cause got %0h want b", bus.mcause); end
        checks++; if (bus.pcSource !== 3'd4 || bus.pcWrite !== 1'b1) begin errors++; $display("FAIL ecall_vector got %0h/%0b want 4/1", bus.pcSource, bus.pcWrite); end
        step();
        checks++; if (bus.state !== 3'd1 || bus.mie !== 1'b0 || bus.mpie !== 1'b1) begin errors++; $display("FAIL ecall_after got %0h/%0b/%0b want 1/0/1", bus.state, bus.mie, bus.mpie); end
    endtask

    task automatic test_interrupt();
        bus.csr_mie_we = 1; bus.csr_mie_wdata = 1;
        step(); clear_inputs();
        step();
        bus.is_jal = 1; bus.intr = 1; #1;
        checks++; if (bus.pcSource !== 3'd3 || bus.pcWrite !== 1'b1) begin errors++; $display("FAIL intr_exec got %0h/%0b want 3/1", bus.pcSource, bus.pcWrite); end
        step(); clear_inputs();
        checks++; if (bus.state !== 3'd4 || bus.mcause !== 32'h8000_000B) begin errors++; $display("FAIL intr_trap got %0h/%0h want 4/8000000b", bus.state, bus.mcause); end
        step();
        checks++; if (bus.mie !== 1'b0 || bus.mpie !== 1'b1) begin errors++; $display("FAIL intr_after got %0b/%0b want 0/1", bus.mie, bus.mpie); end
        to_exec();
        bus.is_jal = 1; bus.intr = 1; #1;
        checks++; if (bus.pcSource !== 3'd3 || bus.pcWrite !== 1'b1) begin errors++; $display("FAIL masked_exec got %0h/%0b want 3/1", bus.pcSource, bus.pcWrite); end
        step(); clear_inputs();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL masked_no_trap got %0h want 1", bus.state); end
    endtask

    task automatic test_mret();
        to_exec();
        bus.is_mret = 1; bus.intr = 1; #1;
        checks++; if (bus.pcSource !== 3'd5 || bus.pcWrite !== 1'b1) begin errors++; $display("FAIL mret_exec got %0h/%0b want 5/1", bus.pcSource, bus.pcWrite); end
        step();
        bus.is_mret = 0; #1;
        checks++; if (bus.state !== 3'd1 || bus.mie !== 1'b1 || bus.mpie !== 1'b1) begin errors++; $display("FAIL mret_after got %0h/%0b/%0b want 1/1/1", bus.state, bus.mie, bus.mpie); end
        to_exec();
        checks++; if (bus.pcSource !== 3'd0 || bus.pcWrite !== 1'b1) begin errors++; $display("FAIL mret_next_exec got %0h/%0b want 0/1", bus.pcSource, bus.pcWrite); end
        step(); clear_inputs();
        checks++; if (bus.state !== 3'd4 || bus.mcause !== 32'h8000_000B) begin errors++; $display("FAIL mret_intr_trap got %0h/%0h want 4/8000000b", bus.state, bus.mcause); end
        step();
    endtask

    task automatic test_illegal();
        to_exec();
        bus.illegal = 1; #1;
        checks++; if (bus.pcWrite !== 1'b0) begin errors++; $display("FAIL illegal_exec got %0b want 0", bus.pcWrite); end
        step(); clear_inputs();
        bus.csr_mie_we = 1; bus.csr_mie_wdata = 1; #1;
        checks++; if (bus.state !== 3'd4 || bus.mcause !== 32'h0000_0002) begin errors++; $display("FAIL illegal_trap got %0h/%0h want 4/2", bus.state, bus.mcause); end
        step(); clear_inputs();
        checks++; if (bus.mie !== 1'b0) begin errors++; $display("FAIL trap_beats_csr got %0b want 0", bus.mie); end
    endtask

    task automatic test_reset_mid_trap();
        to_exec();
        bus.is_ecall = 1;
        step(); clear_inputs();
        reset_n = 0; #1;
        checks++; if (bus.state !== 3'd0 || bus.pc_reset !== 1'b1 || bus.mepcWrite !== 1'b0 || bus.mcauseWrite !== 1'b0) begin errors++; $display("FAIL midtrap_reset got %0h/%0b/%0b/%0b want 0/1/0/0", bus.state, bus.pc_reset, bus.mepcWrite, bus.mcauseWrite); end
        checks++; if (bus.mcause !== 32'h0 || bus.pcWrite !== 1'b0) begin errors++; $display("FAIL midtrap_regs got %0h/%0b want 0/0", bus.mcause, bus.pcWrite); end
        step();
        reset_n = 1;
        step();
        checks++; if (bus.state !== 3'd1 || bus.mepcWrite !== 1'b0) begin errors++; $display("FAIL midtrap_restart got %0h/%0b want 1/0", bus.state, bus.mepcWrite); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_pc_select();
        test_stall();
        test_ecall();
        test_interrupt();
        test_mret();
        test_illegal();
        test_reset_mid_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_trap_sequencer.md
PC_TRAP_SEQUENCER -- requirements
Module: pc_trap_sequencer

Interface
REQ-001 Parameter INTR_CAUSE, default 32'h8000_000B: the mcause value for an external interrupt.
REQ-002 Parameter ILLEGAL_TRAP, default 1: when 1, illegal instructions trap; when 0, they retire as no-ops.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 exec_stall  input  1  holds EXEC while high (for example, a memory wait).
REQ-006 is_jal, is_jalr, is_branch, is_mret, is_ecall, illegal  input  1 each  decoded class of the current instruction; at most one is high.
REQ-007 br_taken  input  1  branch condition result; only meaningful when is_branch is high.
REQ-008 intr  input  1  level-sensitive external interrupt request.
REQ-009 csr_mie_we, csr_mie_wdata  input  1 each  software write of the mie bit.
REQ-010 pcSource  output  3  PC mux select: 000 PC+4, 001 jalr, 010 branch, 011 jal, 100 mtvec, 101 mepc.
REQ-011 pcWrite, pc_reset, irWrite, mepcWrite, mcauseWrite  output  1 each  strobes to the PC, instruction register and CSR file.
REQ-012 mcause  output  32  cause value, valid only while mcauseWrite is high.
REQ-013 mie, mpie  output  1 each  interrupt-enable bit and previous interrupt-enable bit.
REQ-014 state  output  3  current state encoding, for debug.

Function
REQ-015 States and encodings: INIT=000, FETCH=001, DECODE=010, EXEC=011, TRAP=100. Encodings 101–111 go to INIT on the next clock.
REQ-016 INIT: pc_reset=1. Next state is always FETCH.
REQ-017 FETCH: irWrite=1. Next state is DECODE.
REQ-018 DECODE: all strobes 0. Next state is EXEC.
REQ-019 EXEC with exec_stall=1: all strobes 0; stay in EXEC.
REQ-020 EXEC with exec_stall=0, in priority order:
- is_ecall, or illegal with ILLEGAL_TRAP=1: pcWrite=0; next state TRAP, cause latched.
- is_mret: pcSource=101, pcWrite=1; mie<=mpie, mpie<=1.
- is_jalr: pcSource=001. is_jal: pcSource=011.
- is_branch and br_taken: pcSource=010.
- Otherwise: pcSource=000.
- In every non-trap case above, pcWrite=1.
REQ-021 Interrupt-taken condition: intr=1 AND the mie value registered before this cycle = 1 AND the instruction is not trapping. When true, the normal PC update still occurs and the next state is TRAP with cause INTR_CAUSE; otherwise the next state is FETCH.
REQ-022 Latched cause values: ecall = 32'h0000_000B; illegal = 32'h0000_0002; interrupt = INTR_CAUSE.
REQ-023 TRAP, a single cycle:
- mepcWrite=1 (the CSR file captures the current pc_out).
- mcauseWrite=1, with mcause driving the latched cause.
- pcSource=100, pcWrite=1.
- mpie<=mie, mie<=0.
- Next state is FETCH.
REQ-024 Resulting mepc: for ecall/illegal it holds the faulting instruction address; for an interrupt it holds the address of the next instruction.
REQ-025 The csr_mie_we write to mie is applied in any state, except that TRAP and an mret completion take precedence over it in the same cycle.
REQ-026 Outputs are combinational from the state and current inputs (Mealy). The state, mie, mpie and latched cause are registered.
REQ-027 pcSource is 000 in every state where pcWrite=0.
REQ-028 A new intr assertion during FETCH, DECODE or a stalled EXEC has no effect until the non-stalled EXEC cycle.

Reset
REQ-029 While reset_n=0, immediately and without a clock edge:
- State is INIT.
- pc_reset=1.
- mie=0, mpie=0, latched cause=0.
- All other strobes are 0 and pcSource=000.
REQ-030 Deasserting reset_n in any state, including mid-TRAP, restarts at INIT. No partial mepc or mcause write is reissued.

Verification
REQ-031 Reset release, no stalls, ALU instructions: states INIT, FETCH, DECODE, EXEC, FETCH…; pcWrite=1 with pcSource=000 once every 3 cycles after INIT.
REQ-032 Branch with br_taken=1 then br_taken=0: EXEC pcSource=010 then 000. jalr gives 001, jal gives 011.
REQ-033 exec_stall high for 3 cycles in EXEC: 3 cycles with pcWrite=0 and state=011, then a single pcWrite.
REQ-034 ecall: EXEC pcWrite=0; next cycle is TRAP with mepcWrite=1, mcause=32'h0000_000B, pcSource=100, mie 1→0, mpie=1.
REQ-035 intr=1 with mie=1 on a jal: EXEC pcSource=011 pcWrite=1; then TRAP with mcause=32'h8000_000B. The same stimulus with mie=0 gives no TRAP.
REQ-036 mret with mpie=1 and intr=1 in the same EXEC cycle: pcSource=101, mie becomes 1, no TRAP. The interrupt is taken at the following EXEC.
